// File: rtl/option_fifo.sv
// Show-ahead word buffer feeding the nonogram line solver: a circular RAM plus one output register.
// Optional OPTION_FIFO_STATS_EN adds put-back word count and count high-water mark outputs.
module option_fifo #(
  parameter int SIZE  = 3,
  parameter int DEPTH = 64,
  localparam int IW   = $clog2(2 * SIZE),
  localparam int W    = (SIZE > IW) ? SIZE : IW,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_valid,
  input  logic [W-1:0]  wr_data,
  input  logic          wr_is_index,
  output logic          wr_ready,
  input  logic          pb_valid,
  input  logic [W-1:0]  pb_data,
  input  logic          pb_is_index,
  output logic          pb_overflow,
  output logic [W-1:0]  option,
  output logic          is_index,
  output logic          valid_op,
  input  logic          ready,
  output logic          started,
`ifdef OPTION_FIFO_STATS_EN
  output logic [15:0]   pb_words,
  output logic [CW-1:0] hwm,
`endif
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int RD = DEPTH - 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(RD - 1);

  logic [W:0]    mem [RD];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          not_full, pb_accept, wr_accept, push, pop, load, ram_empty;
  logic [W:0]    push_word;
  logic [CW-1:0] count_next;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Put-back wins arbitration; fullness uses the pre-edge count, so a pop never frees room early.
  always_comb begin
    not_full   = count < CW'(DEPTH);
    wr_ready   = !pb_valid && not_full;
    pb_accept  = pb_valid && not_full;
    wr_accept  = wr_valid && wr_ready;
    push       = pb_accept || wr_accept;
    push_word  = pb_valid ? {pb_is_index, pb_data} : {wr_is_index, wr_data};
    pop        = valid_op && ready;
    ram_empty  = (count == CW'(valid_op));
    load       = (!valid_op || pop) && !ram_empty;
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      option      <= '0;
      is_index    <= 1'b0;
      valid_op    <= 1'b0;
      started     <= 1'b0;
      count       <= '0;
      pb_overflow <= 1'b0;
    end else begin
      count <= count_next;
      if (push) wr_ptr <= next_ptr(wr_ptr);
      // No bypass: a word written to an empty buffer reaches the output one edge later.
      if (load) begin
        {is_index, option} <= mem[rd_ptr];
        rd_ptr             <= next_ptr(rd_ptr);
        valid_op           <= 1'b1;
        started            <= 1'b1;
      end else if (pop) begin
        valid_op <= 1'b0;
      end
      if (pb_valid && !not_full) pb_overflow <= 1'b1;
    end
  end

`ifdef OPTION_FIFO_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pb_words <= '0;
      hwm      <= '0;
    end else begin
      if (pb_accept && (pb_words != 16'hFFFF)) pb_words <= pb_words + 1'b1;
      if (count_next > hwm) hwm <= count_next;
    end
  end
`endif

endmodule

// File: tb/tb_option_fifo.sv
// Directed self-checking bench for option_fifo: record flow, fill/drain with wrap, put-back priority,
// overflow and mid-stream reset. Stats ports are checked when OPTION_FIFO_STATS_EN is defined.
module tb_option_fifo;

  localparam int W  = 3;
  localparam int CW = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_valid, wr_is_index, wr_ready;
  logic [W-1:0]  wr_data;
  logic          pb_valid, pb_is_index, pb_overflow;
  logic [W-1:0]  pb_data;
  logic [W-1:0]  option;
  logic          is_index, valid_op, ready, started;
  logic [CW-1:0] count;
`ifdef OPTION_FIFO_STATS_EN
  logic [15:0]   pb_words;
  logic [CW-1:0] hwm;
`endif

  int checks = 0;
  int errors = 0;

  option_fifo dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_is_index(wr_is_index), .wr_ready(wr_ready),
    .pb_valid(pb_valid), .pb_data(pb_data), .pb_is_index(pb_is_index), .pb_overflow(pb_overflow),
    .option(option), .is_index(is_index), .valid_op(valid_op), .ready(ready), .started(started),
`ifdef OPTION_FIFO_STATS_EN
    .pb_words(pb_words), .hwm(hwm),
`endif
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every output must sit at its reset value; used both after power-up and after a mid-stream reset.
  task automatic check_reset_values(input string tag);
    checks++;
    if ({option, is_index, valid_op, started, pb_overflow, wr_ready} !== {3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL %s outputs: option=%b idx=%b valid=%b started=%b ovf=%b wr_ready=%b, want 000 0 0 0 0 1",
               tag, option, is_index, valid_op, started, pb_overflow, wr_ready);
    end
    checks++;
    if (count !== 7'd0) begin
      errors++;
      $display("[TB] FAIL %s count: got %0d want 0", tag, count);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_valid = 0; wr_data = '0; wr_is_index = 0;
    pb_valid = 0; pb_data = '0; pb_is_index = 0; ready = 0;
    #2;
    check_reset_values("reset");
    step(); step();
    rst_n = 1'b1;
    step(); step();
    check_reset_values("idle");
  endtask

  task automatic test_record();
    ready = 1'b1;
    wr_valid = 1; wr_is_index = 1; wr_data = 3'b000;
    step();
    checks++;
    if (valid_op !== 1'b0 || count !== 7'd1) begin
      errors++;
      $display("[TB] FAIL rec_first valid=%b count=%0d, want 0 1", valid_op, count);
    end
    wr_is_index = 0; wr_data = 3'b110;
    step();
    checks++;
    if ({valid_op, is_index, option, started} !== {1'b1, 1'b1, 3'b000, 1'b1}) begin
      errors++;
      $display("[TB] FAIL rec_idx valid=%b idx=%b opt=%b started=%b, want 1 1 000 1",
               valid_op, is_index, option, started);
    end
    wr_data = 3'b011;
    step();
    wr_valid = 0;
    checks++;
    if ({valid_op, is_index, option} !== {1'b1, 1'b0, 3'b110}) begin
      errors++;
      $display("[TB] FAIL rec_opt1 valid=%b idx=%b opt=%b, want 1 0 110", valid_op, is_index, option);
    end
    step();
    checks++;
    if ({valid_op, is_index, option} !== {1'b1, 1'b0, 3'b011}) begin
      errors++;
      $display("[TB] FAIL rec_opt2 valid=%b idx=%b opt=%b, want 1 0 011", valid_op, is_index, option);
    end
    step();
    checks++;
    if (valid_op !== 1'b0 || count !== 7'd0 || started !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rec_end valid=%b count=%0d started=%b, want 0 0 1", valid_op, count, started);
    end
  endtask

  // 64 words fill the RAM and output register, forcing the write pointer across the 63-entry wrap.
  task automatic test_fill_overflow_drain();
    ready = 1'b0;
    for (int i = 0; i < 64; i++) begin
      checks++;
      if (count !== CW'(i) || wr_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL fill_%0d count=%0d wr_ready=%b, want %0d 1", i, count, wr_ready, i);
      end
      wr_valid = 1; wr_data = W'(i); wr_is_index = i[3];
      step();
    end
    wr_valid = 0;
    checks++;
    if (count !== 7'd64 || wr_ready !== 1'b0 || option !== 3'b000 || valid_op !== 1'b1) begin
      errors++;
      $display("[TB] FAIL full count=%0d wr_ready=%b opt=%b valid=%b, want 64 0 000 1",
               count, wr_ready, option, valid_op);
    end
    pb_valid = 1; pb_data = 3'b111; pb_is_index = 1;
    step();
    pb_valid = 0;
    checks++;
    if (pb_overflow !== 1'b1 || count !== 7'd64) begin
      errors++;
      $display("[TB] FAIL overflow ovf=%b count=%0d, want 1 64", pb_overflow, count);
    end
    step();
    checks++;
    if (pb_overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overflow_sticky ovf=%b, want 1", pb_overflow);
    end
    ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      logic [W-1:0] exp_d;
      logic         exp_i;
      exp_d = W'(i);
      exp_i = i[3];
      checks++;
      if (valid_op !== 1'b1 || option !== exp_d || is_index !== exp_i || count !== CW'(64 - i)) begin
        errors++;
        $display("[TB] FAIL drain_%0d valid=%b opt=%b idx=%b count=%0d, want 1 %b %b %0d",
                 i, valid_op, option, is_index, count, exp_d, exp_i, 64 - i);
      end
      step();
    end
    checks++;
    if (valid_op !== 1'b0 || count !== 7'd0) begin
      errors++;
      $display("[TB] FAIL drain_end valid=%b count=%0d, want 0 0", valid_op, count);
    end
  endtask

  task automatic test_pb_priority();
    ready = 1'b0;
    pb_valid = 1; pb_data = 3'b101; pb_is_index = 1;
    wr_valid = 1; wr_data = 3'b010; wr_is_index = 0;
    #1;
    checks++;
    if (wr_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pb_block wr_ready=%b, want 0", wr_ready);
    end
    step();
    pb_valid = 0;
    #1;
    checks++;
    if (wr_ready !== 1'b1 || count !== 7'd1) begin
      errors++;
      $display("[TB] FAIL pb_taken wr_ready=%b count=%0d, want 1 1", wr_ready, count);
    end
    step();
    wr_valid = 0;
    checks++;
    if ({valid_op, is_index, option} !== {1'b1, 1'b1, 3'b101} || count !== 7'd2) begin
      errors++;
      $display("[TB] FAIL pb_head valid=%b idx=%b opt=%b count=%0d, want 1 1 101 2",
               valid_op, is_index, option, count);
    end
    ready = 1'b1;
    step();
    checks++;
    if ({valid_op, is_index, option} !== {1'b1, 1'b0, 3'b010}) begin
      errors++;
      $display("[TB] FAIL gen_after_pb valid=%b idx=%b opt=%b, want 1 0 010", valid_op, is_index, option);
    end
    step();
    checks++;
    if (valid_op !== 1'b0 || count !== 7'd0 || pb_overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pb_end valid=%b count=%0d ovf=%b, want 0 0 1", valid_op, count, pb_overflow);
    end
  endtask

  task automatic test_reset_mid();
    ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      wr_valid = 1; wr_data = W'(i); wr_is_index = 0;
      step();
    end
    wr_valid = 0;
    checks++;
    if (count !== 7'd5 || valid_op !== 1'b1 || option !== 3'b001) begin
      errors++;
      $display("[TB] FAIL pre_reset count=%0d valid=%b opt=%b, want 5 1 001", count, valid_op, option);
    end
`ifdef OPTION_FIFO_STATS_EN
    checks++;
    if (pb_words !== 16'd1 || hwm !== 7'd64) begin
      errors++;
      $display("[TB] FAIL stats pb_words=%0d hwm=%0d, want 1 64", pb_words, hwm);
    end
`endif
    ready = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_reset");
`ifdef OPTION_FIFO_STATS_EN
    checks++;
    if (pb_words !== 16'd0 || hwm !== 7'd0) begin
      errors++;
      $display("[TB] FAIL stats_reset pb_words=%0d hwm=%0d, want 0 0", pb_words, hwm);
    end
`endif
    step(); step();
    rst_n = 1'b1;
    step(); step();
    check_reset_values("post_reset");
  endtask

  initial begin
    test_reset();
    test_record();
    test_fill_overflow_drain();
    test_pb_priority();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
